// File: rtl/frame_sched_pkg.sv
// modem_sched_pkg: shared scheduler state type and default sample-counter sizing
package modem_sched_pkg;
    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} sched_state_t;
    localparam int SYM_LEN = 1024;
    localparam int CNT_W   = $clog2(SYM_LEN);
endpackage

// File: rtl/frame_sched.sv
// frame_sched: gates a continuous IQ stream into fixed-length bursts separated by a programmable gap
// Ports: iclk/irst (sync, active-high); istart/istop/inum_frames/igap/ictrl run control;
// ival/idata/iready sample input; oval/osop/olast/odata registered burst output;
// octrl latched mode; obusy/odone/odrop/ofrm_cnt run status.
module frame_sched
    import modem_sched_pkg::*;
#(
    parameter int pDAT_W   = 32,
    parameter int pSYM_LEN = SYM_LEN,
    parameter int pGAP_W   = 20,
    parameter int pFRM_W   = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              istop,
    input  logic [pFRM_W-1:0] inum_frames,
    input  logic [pGAP_W-1:0] igap,
    input  logic [1:0]        ictrl,
    input  logic              ival,
    input  logic [pDAT_W-1:0] idata,
    input  logic              iready,
    output logic              oval,
    output logic              osop,
    output logic              olast,
    output logic [pDAT_W-1:0] odata,
    output logic [1:0]        octrl,
    output logic              obusy,
    output logic              odone,
    output logic              odrop,
    output logic [pFRM_W-1:0] ofrm_cnt
);
    localparam int CW = $clog2(pSYM_LEN);
    localparam logic [CW-1:0] LAST = CW'(pSYM_LEN - 1);

    sched_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [pGAP_W-1:0] gap_q, gap_d, igap_q, igap_d;
    logic [pFRM_W-1:0] frm_q, frm_d, nfrm_q, nfrm_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              stop_q, stop_d;
    logic              val_q, sop_q, last_q, drop_q;
    logic [pDAT_W-1:0] data_q;
    logic              acc, fin, pend;

    assign acc  = (state_q == BURST) & ival & iready;
    assign fin  = acc & (cnt_q == LAST);
    // a stop raised in the same cycle as the deciding sample still counts as pending
    assign pend = stop_q | istop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        frm_d   = frm_q;
        nfrm_d  = nfrm_q;
        igap_d  = igap_q;
        ctrl_d  = ctrl_q;
        stop_d  = stop_q | (istop & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                stop_d = istart & istop;
                if (istart) begin
                    nfrm_d  = inum_frames;
                    igap_d  = igap;
                    ctrl_d  = ictrl;
                    cnt_d   = '0;
                    frm_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (acc) cnt_d = fin ? '0 : cnt_q + 1'b1;
                if (fin) begin
                    frm_d   = frm_q + 1'b1;
                    gap_d   = igap_q;
                    state_d = (pend || (nfrm_q != '0 && (frm_q + 1'b1) == nfrm_q)) ? DONE :
                              (igap_q != '0) ? GAP : BURST;
                end
            end
            GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = pend ? DONE : (gap_q == 1) ? BURST : GAP;
            end
            DONE: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            frm_q   <= '0;
            nfrm_q  <= '0;
            igap_q  <= '0;
            ctrl_q  <= '0;
            stop_q  <= 1'b0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            frm_q   <= frm_d;
            nfrm_q  <= nfrm_d;
            igap_q  <= igap_d;
            ctrl_q  <= ctrl_d;
            stop_q  <= stop_d;
            val_q   <= acc;
            sop_q   <= acc & (cnt_q == '0);
            last_q  <= fin;
            drop_q  <= (state_q == BURST) & ival & ~iready;
            if (acc) data_q <= idata;
        end
    end

    assign oval     = val_q;
    assign osop     = sop_q;
    assign olast    = last_q;
    assign odata    = data_q;
    assign octrl    = ctrl_q;
    assign obusy    = state_q != IDLE;
    assign odone    = state_q == DONE;
    assign odrop    = drop_q;
    assign ofrm_cnt = frm_q;
endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: randomized and scenario stimulus against a behavioural frame scheduler model
module tb_frame_sched;
    localparam int LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, stop = 1'b0, val = 1'b0, rdy = 1'b0;
    logic [7:0]  nfr = '0;
    logic [19:0] gap = '0;
    logic [1:0]  ctrl = '0;
    logic [31:0] data = '0;
    logic        oval, osop, olast, obusy, odone, odrop;
    logic [31:0] odata;
    logic [1:0]  octrl;
    logic [7:0]  ofrm_cnt;

    frame_sched #(.pDAT_W(32), .pSYM_LEN(LEN), .pGAP_W(20), .pFRM_W(8)) dut (
        .iclk(clk), .irst(rst), .istart(start), .istop(stop), .inum_frames(nfr),
        .igap(gap), .ictrl(ctrl), .ival(val), .idata(data), .iready(rdy),
        .oval(oval), .osop(osop), .olast(olast), .odata(odata), .octrl(octrl),
        .obusy(obusy), .odone(odone), .odrop(odrop), .ofrm_cnt(ofrm_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc_n = 0;
    int beats = 0, drops = 0, dones = 0, first_v = -1, last_v = -1, sop_n = 0, last_n = 0;

    bit        m_busy, m_fin, m_stop;
    int        m_gap, m_idx, m_frames, m_target, m_gap_len;
    bit [1:0]  m_ctrl;
    bit [31:0] m_data;
    bit        e_val, e_sop, e_last, e_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_n);
    endtask

    task automatic model_step();
        bit pend;
        e_val = 0; e_sop = 0; e_last = 0; e_drop = 0;
        if (rst) begin
            m_busy = 0; m_fin = 0; m_stop = 0; m_gap = 0; m_idx = 0;
            m_frames = 0; m_ctrl = 0; m_data = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_target = nfr; m_gap_len = gap; m_ctrl = ctrl;
                m_idx = 0; m_frames = 0; m_stop = stop;
            end
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0; m_stop = 0;
        end else begin
            pend = m_stop || stop;
            if (m_gap > 0) begin
                if (pend) begin m_gap = 0; m_fin = 1; end
                else m_gap--;
            end else if (val && rdy) begin
                e_val = 1; m_data = data; e_sop = (m_idx == 0); e_last = (m_idx == LEN - 1);
                if (m_idx == LEN - 1) begin
                    m_idx = 0; m_frames++;
                    if (pend || (m_target != 0 && m_frames == m_target)) m_fin = 1;
                    else m_gap = m_gap_len;
                end else m_idx++;
            end else if (val) e_drop = 1;
            if (stop) m_stop = 1;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
        check("oval", oval, e_val);
        check("osop", osop, e_sop);
        check("olast", olast, e_last);
        check("odata", odata, m_data);
        check("octrl", octrl, m_ctrl);
        check("obusy", obusy, m_busy);
        check("odone", odone, m_fin);
        check("odrop", odrop, e_drop);
        check("ofrm_cnt", ofrm_cnt, m_frames[7:0]);
        if (oval) begin
            beats++; last_v = cyc_n;
            if (first_v < 0) first_v = cyc_n;
        end
        sop_n += osop; last_n += olast; drops += odrop; dones += odone;
        data = $urandom;
    endtask

    task automatic clr();
        beats = 0; drops = 0; dones = 0; first_v = -1; last_v = -1; sop_n = 0; last_n = 0;
    endtask

    task automatic go(input int f, input int g, input int c);
        nfr = 8'(f); gap = 20'(g); ctrl = 2'(c); start = 1; cyc(); start = 0;
    endtask

    task automatic run(input int max);
        int n = 0;
        while (m_busy && n < max) begin cyc(); n++; end
        check("run_timeout", 64'(m_busy), 64'd0);
        repeat (2) cyc();
    endtask

    task automatic wait_idx(input int fr, input int idx);
        int n = 0;
        while (!(m_frames == fr && m_idx == idx) && n < 500) begin cyc(); n++; end
        check("wait_timeout", 64'(n < 500), 64'd1);
    endtask

    initial begin
        rst = 1; repeat (2) cyc(); rst = 0; cyc();
        check("reset_busy", obusy, 0);

        clr(); val = 1; rdy = 1; go(2, 5, 2); run(300);
        check("s1_beats", beats, 32);
        check("s1_sops", sop_n, 2);
        check("s1_lasts", last_n, 2);
        check("s1_span", last_v - first_v + 1, 32 + 5);
        check("s1_done", dones, 1);
        check("s1_frm", ofrm_cnt, 2);

        clr(); go(3, 0, 1); run(300);
        check("s2_beats", beats, 48);
        check("s2_span", last_v - first_v + 1, 48);
        check("s2_frm", ofrm_cnt, 3);

        clr(); go(1, 0, 0);
        repeat (6) cyc();
        rdy = 0; repeat (3) cyc(); rdy = 1;
        run(300);
        check("s3_drops", drops, 3);
        check("s3_beats", beats, 16);
        check("s3_span", last_v - first_v + 1, 16 + 3);

        clr(); go(0, 2, 1); wait_idx(3, 7);
        stop = 1; cyc(); stop = 0; run(300);
        check("s4_frm", ofrm_cnt, 4);
        check("s4_lasts", last_n, 4);
        check("s4_done", dones, 1);

        clr(); go(2, 1, 3); wait_idx(0, 9);
        rst = 1; cyc(); rst = 0;
        check("s5_rst_busy", obusy, 0);
        cyc();
        check("s5_no_last", last_n, 0);
        clr(); go(1, 0, 3); cyc();
        check("s5_restart_sop", osop, 1);
        run(300);

        clr(); go(2, 3, 3); repeat (10) cyc();
        ctrl = 1; start = 1; cyc(); start = 0;
        check("s6_octrl", octrl, 3);
        run(300);
        check("s6_frm", ofrm_cnt, 2);

        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            val   = ($urandom_range(0, 9) < 8);
            rdy   = ($urandom_range(0, 9) < 8);
            nfr   = 8'($urandom_range(0, 3));
            gap   = 20'($urandom_range(0, 3));
            ctrl  = 2'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
